// File: rtl/option_menu.sv
// Vertical option menu: click-to-select buttons overlaid on a VGA pixel stream.
`ifndef VGA_MACROS_SV
`define VGA_MACROS_SV
`define VGA_BUS_SIZE 40
`define VGA_RGB(b)    b[11:0]
`define VGA_HBLNK(b)  b[12]
`define VGA_HSYNC(b)  b[13]
`define VGA_HCOUNT(b) b[25:14]
`define VGA_VBLNK(b)  b[26]
`define VGA_VSYNC(b)  b[27]
`define VGA_VCOUNT(b) b[39:28]
`endif

module option_menu #(
    parameter int unsigned NUM_OPTIONS = 3,
    parameter int unsigned X_POS       = 400,
    parameter int unsigned Y_POS       = 200,
    parameter int unsigned BTN_WIDTH   = 200,
    parameter int unsigned BTN_HEIGHT  = 60,
    parameter int unsigned BTN_GAP     = 20,
    parameter int unsigned DEFAULT_SEL = 1,
    parameter int unsigned VALUE_W     = 6,
    parameter logic [NUM_OPTIONS*VALUE_W-1:0] OPTION_VALUES = {6'd24, 6'd16, 6'd8},
    parameter logic [11:0] COLOR_IDLE  = 12'h444,
    parameter logic [11:0] COLOR_HOVER = 12'h888,
    parameter logic [11:0] COLOR_SEL   = 12'h0F0,
    localparam int unsigned IDX_W = (NUM_OPTIONS <= 2) ? 1 : $clog2(NUM_OPTIONS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mouse_left,
    input  logic [11:0]              mouse_xpos,
    input  logic [11:0]              mouse_ypos,
    input  logic [`VGA_BUS_SIZE-1:0] vga_in,
    output logic [`VGA_BUS_SIZE-1:0] vga_out,
    output logic [IDX_W-1:0]         sel_idx,
    output logic [VALUE_W-1:0]       sel_value,
    output logic                     commit_pulse
);

    localparam int unsigned PITCH = BTN_HEIGHT + BTN_GAP;
    localparam logic [11:0] X_LO  = 12'(X_POS);
    localparam logic [11:0] X_HI  = 12'(X_POS + BTN_WIDTH);
    localparam logic [VALUE_W-1:0] DEFAULT_VALUE = OPTION_VALUES[DEFAULT_SEL*VALUE_W +: VALUE_W];

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

    // Point-in-button test; bounds fold to constants per unrolled button index.
    function automatic logic in_btn(input logic [11:0] x, input logic [11:0] y,
                                    input int unsigned i);
        logic [11:0] y_lo;
        logic [11:0] y_hi;
        y_lo = 12'(Y_POS + i * PITCH);
        y_hi = 12'(Y_POS + i * PITCH + BTN_HEIGHT);
        return (x >= X_LO) && (x < X_HI) && (y >= y_lo) && (y < y_hi);
    endfunction

    // Option value lookup without a variable-width multiply on the index.
    function automatic logic [VALUE_W-1:0] value_of(input logic [IDX_W-1:0] idx);
        logic [VALUE_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_OPTIONS; i++) begin
            if (idx == IDX_W'(i)) v = OPTION_VALUES[i*VALUE_W +: VALUE_W];
        end
        return v;
    endfunction

    state_t                   state_q, state_d;
    logic                     prev_q;
    logic [IDX_W-1:0]         armed_idx_q, armed_idx_d;
    logic [IDX_W-1:0]         sel_idx_q, sel_idx_d;
    logic [VALUE_W-1:0]       sel_value_q, sel_value_d;
    logic                     commit_pulse_q, commit_pulse_d;
    logic [`VGA_BUS_SIZE-1:0] vga_out_q, vga_out_d;

    logic [NUM_OPTIONS-1:0]   cur_hit_c;
    logic                     any_hit_c;
    logic [IDX_W-1:0]         hit_idx_c;
    logic                     armed_hit_c;
    logic                     rise_c;
    logic                     commit_c;

    // Cursor decode: which button the mouse is over, and whether it is the armed one.
    always_comb begin
        cur_hit_c   = '0;
        any_hit_c   = 1'b0;
        hit_idx_c   = '0;
        armed_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_OPTIONS; i++) begin
            cur_hit_c[i] = in_btn(mouse_xpos, mouse_ypos, i);
            if (cur_hit_c[i] && !any_hit_c) begin
                any_hit_c = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (cur_hit_c[i] && (armed_idx_q == IDX_W'(i))) armed_hit_c = 1'b1;
        end
    end

    assign rise_c = mouse_left & ~prev_q;

    // Click FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Click FSM next state: arm on a fresh press over a button, drop on release or disable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && rise_c && any_hit_c) state_d = ARMED;
            ARMED:   if (!enable || !mouse_left)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Click FSM outputs: latch armed button, commit on release over the same button.
    always_comb begin
        armed_idx_d    = armed_idx_q;
        commit_c       = 1'b0;
        if (state_q == IDLE && enable && rise_c && any_hit_c) armed_idx_d = hit_idx_c;
        if (state_q == ARMED && enable && !mouse_left && armed_hit_c) commit_c = 1'b1;
        sel_idx_d      = commit_c ? armed_idx_q : sel_idx_q;
        sel_value_d    = commit_c ? value_of(armed_idx_q) : sel_value_q;
        commit_pulse_d = commit_c;
    end

    // Overlay: recolour pixels inside buttons, everything else passes through.
    always_comb begin
        vga_out_d = vga_in;
        if (enable) begin
            for (int unsigned i = 0; i < NUM_OPTIONS; i++) begin
                if (in_btn(`VGA_HCOUNT(vga_in), `VGA_VCOUNT(vga_in), i)) begin
                    if (sel_idx_q == IDX_W'(i))  `VGA_RGB(vga_out_d) = COLOR_SEL;
                    else if (cur_hit_c[i])       `VGA_RGB(vga_out_d) = COLOR_HOVER;
                    else                         `VGA_RGB(vga_out_d) = COLOR_IDLE;
                end
            end
        end
    end

    // Datapath registers: button history, selection, strobe and delayed VGA bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q         <= 1'b0;
            armed_idx_q    <= '0;
            sel_idx_q      <= IDX_W'(DEFAULT_SEL);
            sel_value_q    <= DEFAULT_VALUE;
            commit_pulse_q <= 1'b0;
            vga_out_q      <= '0;
        end else begin
            prev_q         <= mouse_left;
            armed_idx_q    <= armed_idx_d;
            sel_idx_q      <= sel_idx_d;
            sel_value_q    <= sel_value_d;
            commit_pulse_q <= commit_pulse_d;
            vga_out_q      <= vga_out_d;
        end
    end

    assign vga_out      = vga_out_q;
    assign sel_idx      = sel_idx_q;
    assign sel_value    = sel_value_q;
    assign commit_pulse = commit_pulse_q;

endmodule
